// File: rtl/svn_seg_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : svn_seg_scan_if
// Brief    : Load/convert handshake and display options for svn_seg_scan.
// Revision : 1.0
// ============================================================================
interface svn_seg_scan_if;
    logic       load;
    logic [5:0] val_hi;
    logic [5:0] val_lo;
    logic       blank_lz;
    logic       dp_en;
    logic       busy;
    logic       done;

    modport master (
        output load,
        output val_hi,
        output val_lo,
        output blank_lz,
        output dp_en,
        input  busy,
        input  done
    );

    modport slave (
        input  load,
        input  val_hi,
        input  val_lo,
        input  blank_lz,
        input  dp_en,
        output busy,
        output done
    );
endinterface
`default_nettype wire

// File: rtl/svn_seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : svn_seg_scan
// Brief    : Two 0..63 values to decimal, multiplexed onto a 4-digit display.
// Revision : 1.0
// ============================================================================
module svn_seg_scan #(
    parameter int CLK_DIV = 50000
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    svn_seg_scan_if.slave     bus,
    output logic [3:0]        an,
    output logic [7:0]        seg
);

    localparam int            c_CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONV_HI = 2'd1,
        S_CONV_LO = 2'd2,
        S_COMMIT  = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic         w_busy;
    logic         w_done;

    logic [5:0]   r_rem_hi;
    logic [5:0]   r_rem_lo;
    logic [3:0]   r_tens_hi;
    logic [3:0]   r_ones_hi;
    logic [3:0]   r_tens_lo;
    logic [3:0]   r_ones_lo;

    logic [3:0]   r_disp_tens_hi;
    logic [3:0]   r_disp_ones_hi;
    logic [3:0]   r_disp_tens_lo;
    logic [3:0]   r_disp_ones_lo;

    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]   r_idx;
    logic         w_tick;

    logic [3:0]   w_digit;
    logic [3:0]   w_an_nxt;
    logic [7:0]   w_seg_nxt;

    // Active-low g..a pattern; out-of-range codes render dark.
    function automatic logic [6:0] f_enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = (r_state != S_IDLE);
        w_done      = (r_state == S_COMMIT);
        case (r_state)
            S_IDLE:    if (bus.load) w_state_nxt = S_CONV_HI;
            S_CONV_HI: if (r_rem_hi < 6'd10) w_state_nxt = S_CONV_LO;
            S_CONV_LO: if (r_rem_lo < 6'd10) w_state_nxt = S_COMMIT;
            S_COMMIT:  w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.busy = w_busy;
    assign bus.done = w_done;

    // Repeated subtraction: one cycle per tens step plus one to latch the ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem_hi       <= '0;
            r_rem_lo       <= '0;
            r_tens_hi      <= '0;
            r_ones_hi      <= '0;
            r_tens_lo      <= '0;
            r_ones_lo      <= '0;
            r_disp_tens_hi <= '0;
            r_disp_ones_hi <= '0;
            r_disp_tens_lo <= '0;
            r_disp_ones_lo <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.load) begin
                        r_rem_hi  <= bus.val_hi;
                        r_rem_lo  <= bus.val_lo;
                        r_tens_hi <= '0;
                        r_tens_lo <= '0;
                    end
                end
                S_CONV_HI: begin
                    if (r_rem_hi >= 6'd10) begin
                        r_rem_hi  <= r_rem_hi - 6'd10;
                        r_tens_hi <= r_tens_hi + 4'd1;
                    end else begin
                        r_ones_hi <= r_rem_hi[3:0];
                    end
                end
                S_CONV_LO: begin
                    if (r_rem_lo >= 6'd10) begin
                        r_rem_lo  <= r_rem_lo - 6'd10;
                        r_tens_lo <= r_tens_lo + 4'd1;
                    end else begin
                        r_ones_lo <= r_rem_lo[3:0];
                    end
                end
                S_COMMIT: begin
                    r_disp_tens_hi <= r_tens_hi;
                    r_disp_ones_hi <= r_ones_hi;
                    r_disp_tens_lo <= r_tens_lo;
                    r_disp_ones_lo <= r_ones_lo;
                end
                default: ;
            endcase
        end
    end

    assign w_tick = (r_cnt == c_CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else begin
            if (w_tick) begin
                r_cnt <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_digit = 4'd0;
        case (r_idx)
            2'd0: w_digit = r_disp_ones_lo;
            2'd1: w_digit = r_disp_tens_lo;
            2'd2: w_digit = r_disp_ones_hi;
            2'd3: w_digit = r_disp_tens_hi;
            default: w_digit = 4'd0;
        endcase

        w_an_nxt  = ~(4'b0001 << r_idx);
        w_seg_nxt = {1'b1, f_enc(w_digit)};
        // Odd indices are the tens positions; a leading zero may go dark.
        if (r_idx[0] && (w_digit == 4'd0) && bus.blank_lz) begin
            w_seg_nxt = 8'hFF;
        end
        if ((r_idx == 2'd2) && bus.dp_en) begin
            w_seg_nxt[7] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= 4'b1111;
            seg <= 8'hFF;
        end else begin
            an  <= w_an_nxt;
            seg <= w_seg_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_svn_seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_svn_seg_scan
// Brief    : Directed, table-driven bench for svn_seg_scan with CLK_DIV = 4.
// Revision : 1.0
// ============================================================================
module tb_svn_seg_scan;

    localparam int CLK_DIV = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] an;
    logic [7:0] seg;

    svn_seg_scan_if bus_if ();

    svn_seg_scan #(.CLK_DIV(CLK_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave),
        .an    (an),
        .seg   (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  hi;
        logic [5:0]  lo;
        logic        blz;
        logic        dp;
        int          busy_cyc;
        int          reload_at;
        logic [31:0] segs;      // {digit3, digit2, digit1, digit0}
    } vec_t;

    vec_t vecs [8];
    int   errors;
    int   checks;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sweep_digits(input string tag, input logic [31:0] exp_segs);
        for (int d = 0; d < 4; d++) begin
            logic [3:0] target;
            logic       found;
            target = ~(4'b0001 << d);
            found  = 1'b0;
            for (int k = 0; k < 64; k++) begin
                if (an == target) begin
                    found = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            chk($sformatf("%s_an%0d_seen", tag, d), {31'd0, found}, 32'd1);
            chk($sformatf("%s_seg%0d", tag, d), {24'd0, seg}, {24'd0, exp_segs[8*d +: 8]});
        end
    endtask

    task automatic check_current(input string tag, input logic [31:0] exp_segs);
        int idx;
        idx = -1;
        for (int i = 0; i < 4; i++) begin
            if (an == ~(4'b0001 << i)) idx = i;
        end
        if (idx < 0) begin
            chk({tag, "_imm_an"}, {28'd0, an}, 32'h0000000E);
        end else begin
            chk({tag, "_imm_seg"}, {24'd0, seg}, {24'd0, exp_segs[8*idx +: 8]});
        end
    endtask

    initial begin
        int bc;
        int dn;
        logic [3:0] exp_an;

        errors = 0;
        checks = 0;

        vecs[0] = '{6'd45, 6'd7,  1'b0, 1'b0, 7,  0, 32'h9992C0F8};
        vecs[1] = '{6'd45, 6'd7,  1'b1, 1'b1, 7,  0, 32'h9912FFF8};
        vecs[2] = '{6'd63, 6'd63, 1'b0, 1'b0, 15, 5, 32'h82B082B0};
        vecs[3] = '{6'd0,  6'd0,  1'b1, 1'b0, 3,  0, 32'hFFC0FFC0};
        vecs[4] = '{6'd10, 6'd59, 1'b0, 1'b1, 9,  0, 32'hF9409290};
        vecs[5] = '{6'd9,  6'd20, 1'b1, 1'b0, 5,  0, 32'hFF90A4C0};
        vecs[6] = '{6'd38, 6'd14, 1'b0, 1'b0, 7,  0, 32'hB080F999};
        vecs[7] = '{6'd57, 6'd26, 1'b0, 1'b0, 10, 0, 32'h92F8A482};

        rst_n           = 1'b0;
        bus_if.load     = 1'b0;
        bus_if.val_hi   = 6'd0;
        bus_if.val_lo   = 6'd0;
        bus_if.blank_lz = 1'b0;
        bus_if.dp_en    = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, bus_if.busy}, 32'd0);
        chk("rst_done", {31'd0, bus_if.done}, 32'd0);
        chk("rst_an",   {28'd0, an}, 32'hF);
        chk("rst_seg",  {24'd0, seg}, 32'hFF);

        // Release away from the edge; each sample k is k+1 edges after release.
        rst_n = 1'b1;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            exp_an = ~(4'b0001 << ((k / CLK_DIV) % 4));
            chk($sformatf("scan_an_%0d", k), {28'd0, an}, {28'd0, exp_an});
            chk($sformatf("scan_seg_%0d", k), {24'd0, seg}, 32'hC0);
        end

        for (int v = 0; v < 8; v++) begin
            bus_if.val_hi   = vecs[v].hi;
            bus_if.val_lo   = vecs[v].lo;
            bus_if.blank_lz = vecs[v].blz;
            bus_if.dp_en    = vecs[v].dp;
            bus_if.load     = 1'b1;
            bc = 0;
            dn = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                bus_if.load = 1'b0;
                if (bus_if.busy) bc++;
                if (bus_if.done) dn++;
                if (bus_if.busy && (bc == vecs[v].reload_at)) begin
                    bus_if.load   = 1'b1;
                    bus_if.val_hi = 6'd0;
                    bus_if.val_lo = 6'd0;
                end
                if (!bus_if.busy) break;
            end
            chk($sformatf("v%0d_busy_cycles", v), bc, vecs[v].busy_cyc);
            chk($sformatf("v%0d_done_pulses", v), dn, 1);
            @(negedge clk);
            check_current($sformatf("v%0d", v), vecs[v].segs);
            sweep_digits($sformatf("v%0d", v), vecs[v].segs);
        end

        // Reset during the low-value conversion of 59/59 (busy cycles 7..12).
        bus_if.val_hi   = 6'd59;
        bus_if.val_lo   = 6'd59;
        bus_if.blank_lz = 1'b0;
        bus_if.dp_en    = 1'b0;
        bus_if.load     = 1'b1;
        bc = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            bus_if.load = 1'b0;
            if (bus_if.busy) bc++;
            if (bc == 8 || !bus_if.busy) break;
        end
        chk("abort_reached_conv_lo", bc, 8);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, bus_if.busy}, 32'd0);
        chk("abort_an",   {28'd0, an}, 32'hF);
        chk("abort_seg",  {24'd0, seg}, 32'hFF);
        dn = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus_if.done) dn++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus_if.done) dn++;
        end
        chk("abort_no_done", dn, 0);
        sweep_digits("abort", 32'hC0C0C0C0);

        // load held high: 12/3 converts in 4 cycles, then one idle cycle.
        bus_if.val_hi = 6'd12;
        bus_if.val_lo = 6'd3;
        bus_if.load   = 1'b1;
        dn = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus_if.done) dn++;
            chk($sformatf("hold_k%0d", k), {30'd0, bus_if.busy, bus_if.done},
                {30'd0, ((k % 5) != 4), ((k % 5) == 3)});
        end
        bus_if.load = 1'b0;
        chk("hold_done_count", dn, 4);
        repeat (3) @(negedge clk);
        chk("hold_idle", {31'd0, bus_if.busy}, 32'd0);
        sweep_digits("hold", 32'hF9A4C0B0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
